load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BYTES, default 128, size of the attached data memory in bytes; valid byte addresses are 0..MEM_BYTES-1.
REQ-002 clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  1  CPU access request, sampled only in IDLE.
REQ-005 we_i  input  1  1 = store, 0 = load.
REQ-006 size_i  input  2  00 = byte, 01 = halfword, 10 = word; 11 is reserved and treated as an error.
REQ-007 sign_i  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-008 addr_i  input  32  CPU byte address.
REQ-009 wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 busy_o  output  1  high in every state except IDLE.
REQ-011 done_o  output  1  one-cycle completion pulse.
REQ-012 err_o  output  1  qualifies done_o: access rejected.
REQ-013 rdata_o  output  32  load result, valid while done_o=1 and err_o=0.
REQ-014 mem_addr_o  output  32  word-aligned address to memory.
REQ-015 mem_wdata_o  output  32  write data to memory, little-endian byte lanes.
REQ-016 mem_read_o  output  1  memory read enable.
REQ-017 mem_write_o  output  1  memory write enable; memory commits on the clk_i rising edge.
REQ-018 mem_rdata_i  input  32  memory read data, combinational from mem_addr_o while mem_read_o=1.

Function
REQ-019 Moore FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE.
REQ-020 In IDLE with req_i=1 the block shall latch addr_i, we_i, size_i, sign_i and wdata_i at the clock edge; req_i in any other state shall be ignored.
REQ-021 Error condition: halfword with addr[0]=1, word with addr[1:0]!=0, size_i=11, or addr_i+bytes > MEM_BYTES. On error: IDLE->DONE with err_o=1 and no memory access.
REQ-022 Valid load: IDLE->LOAD->DONE.
REQ-023 Valid word store: IDLE->STORE->DONE.
REQ-024 Valid byte or halfword store: IDLE->RMW_RD->RMW_WR->DONE.
REQ-025 DONE shall last one cycle and then return to IDLE; done_o=1 only in DONE.
REQ-026 mem_addr_o shall be {addr[31:2],2'b00} in LOAD, STORE, RMW_RD and RMW_WR, and 0 otherwise.
REQ-027 mem_read_o shall be 1 only in LOAD and RMW_RD; mem_write_o shall be 1 only in STORE and RMW_WR; the two shall never be 1 together.
REQ-028 In LOAD the block shall capture mem_rdata_i at the edge and select the lane by addr[1:0] (byte lane n = bits [8n+7:8n]; halfword lane = addr[1]).
REQ-029 The selected lane shall be extended to 32 bits per sign_i; a word load returns the full word; the result is held in rdata_o from DONE until the next load DONE.
REQ-030 In RMW_RD the block shall capture the full memory word.
REQ-031 In RMW_WR mem_wdata_o shall be the captured word with only the addressed byte or halfword replaced from wdata_i; all other bytes are unchanged.
REQ-032 In STORE mem_wdata_o shall equal the latched wdata; in all other states mem_wdata_o shall be 0.
REQ-033 Latency from the request edge to done_o: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, error 1 cycle.
REQ-034 A new request is accepted in the IDLE cycle immediately after DONE; back-to-back throughput is one access per 3 or 4 cycles.

Reset
REQ-035 rst_i=0 shall force IDLE immediately, without waiting for a clock edge, including mid-operation; a pending write shall be dropped before the next edge.
REQ-036 Values while in reset: busy_o, done_o, err_o, mem_read_o and mem_write_o = 0; rdata_o, mem_addr_o and mem_wdata_o = 0.
REQ-037 Latched request registers and the captured word shall clear to 0 on reset.

Verification
REQ-038 Word store then load: store 0xDEADBEEF to 0x10, then load word 0x10 -> rdata_o=0xDEADBEEF; done_o 2 cycles after each request.
REQ-039 Byte store: mem[0x10]=0x11223344; store byte 0xAA to 0x12 -> word becomes 0x11AA3344; exactly one mem_write_o cycle; done_o 3 cycles after the request.
REQ-040 Signed and unsigned loads: word 0x8001FF80 at 0x20:
- lb 0x20 signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- lh 0x22 signed -> 0xFFFF8001.
REQ-041 Errors: halfword at 0x21, word at 0x7E, word at 0x80 -> err_o=1 with done_o 1 cycle after the request; mem_read_o and mem_write_o never asserted; memory contents unchanged.
REQ-042 Reset mid-operation: deassert rst_i during RMW_RD of a byte store -> busy_o=0 immediately; no write occurs; memory unchanged; next request served normally.
REQ-043 Request handling: req_i held high continuously -> a new access starts only from IDLE; req_i pulses while busy_o=1 are ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU and a word-wide data memory: handles byte/half/word
// accesses, sign/zero extension, alignment and range errors, and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d, sign_q, sign_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  // Misalignment, reserved size, or access running past the end of memory (33-bit sum avoids wrap).
  function automatic logic access_err(input logic [31:0] a, input logic [1:0] sz);
    logic [32:0] last;
    logic        e;
    e    = 1'b0;
    last = {1'b0, a};
    case (sz)
      2'b00:   last = {1'b0, a} + 33'd1;
      2'b01:   begin last = {1'b0, a} + 33'd2; e = a[0]; end
      2'b10:   begin last = {1'b0, a} + 33'd4; e = |a[1:0]; end
      default: e = 1'b1;
    endcase
    if (last > 33'(MEM_BYTES)) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sg & b[7]}}, b};
      2'b01:   r = {{16{sg & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                        input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (a)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (a[1]) r[31:16] = d[15:0];
      else      r[15:0]  = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    sign_d  = sign_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          we_d    = we_i;
          size_d  = size_i;
          sign_d  = sign_i;
          wdata_d = wdata_i;
          if (access_err(addr_i, size_i)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (!we_i)          state_d = LOAD;
          else if (size_i == 2'b10)    state_d = STORE;
          else                         state_d = RMW_RD;
        end
      end
      LOAD: begin
        rdata_d = load_ext(mem_rdata_i, addr_q[1:0], size_q, sign_q);
        state_d = DONE;
      end
      STORE:   state_d = DONE;
      RMW_RD: begin
        word_d  = mem_rdata_i;
        state_d = RMW_WR;
      end
      RMW_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in that state.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    mem_read_d  = (state_d == LOAD) || (state_d == RMW_RD);
    mem_write_d = (state_d == STORE) || (state_d == RMW_WR);
    mem_addr_d  = (state_d inside {LOAD, STORE, RMW_RD, RMW_WR}) ? {addr_d[31:2], 2'b00} : '0;
    if (state_d == STORE)       mem_wdata_d = wdata_d;
    else if (state_d == RMW_WR) mem_wdata_d = merge(word_d, addr_d[1:0], size_d, wdata_d);
    else                        mem_wdata_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      wdata_q     <= '0;
      word_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table plus scoreboard queue, byte-array memory and reference image.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, sign_i = 1'b0;
  logic [1:0]  size_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        busy_o, done_o, err_o, mem_read_o, mem_write_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;

  load_store_unit #(.MEM_BYTES(128)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sign_i(sign_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   req_cyc;
  } exp_t;

  logic [7:0] mem     [0:127] = '{default: 8'h00};
  logic [7:0] exp_mem [0:127] = '{default: 8'h00};
  exp_t       sb[$];
  exp_t       cur;
  int         n_cmp = 0, n_fail = 0;
  int         cyc = 0;
  int         rd_cnt = 0, wr_cnt = 0, bad_cnt = 0;

  always_comb begin
    mem_rdata_i = '0;
    if (mem_read_o)
      mem_rdata_i = {mem[mem_addr_o[6:0] + 7'd3], mem[mem_addr_o[6:0] + 7'd2],
                     mem[mem_addr_o[6:0] + 7'd1], mem[mem_addr_o[6:0]]};
  end

  always @(posedge clk_i) begin
    if (mem_write_o)
      for (int k = 0; k < 4; k++) mem[mem_addr_o[6:0] + 7'(k)] <= mem_wdata_o[8*k +: 8];
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts memory strobes per access and pops the scoreboard on each done pulse.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      rd_cnt = 0; wr_cnt = 0; bad_cnt = 0;
    end else begin
      if (mem_read_o) rd_cnt++;
      if (mem_write_o) wr_cnt++;
      if (mem_read_o && mem_write_o) bad_cnt++;
      if ((mem_read_o || mem_write_o) && sb.size() > 0 &&
          mem_addr_o !== {sb[0].v.addr[31:2], 2'b00}) bad_cnt++;
      if (done_o) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          check("err", {31'd0, err_o}, {31'd0, cur.v.err});
          check("busy_in_done", {31'd0, busy_o}, 32'd1);
          check("latency", 32'(cyc - cur.req_cyc), 32'(cur.v.lat));
          if (!cur.v.we && !cur.v.err) check("rdata", rdata_o, cur.v.rdata);
          check("read_cycles", 32'(rd_cnt),
                (cur.v.err || (cur.v.we && cur.v.size == 2'b10)) ? 32'd0 : 32'd1);
          check("write_cycles", 32'(wr_cnt), (cur.v.err || !cur.v.we) ? 32'd0 : 32'd1);
          check("addr_or_overlap", 32'(bad_cnt), 32'd0);
        end
        rd_cnt = 0; wr_cnt = 0; bad_cnt = 0;
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input logic er,
                              input logic [31:0] rd, input int lat);
    vec_t v;
    v.we = we; v.size = sz; v.sign = sg; v.addr = a; v.wdata = wd;
    v.err = er; v.rdata = rd; v.lat = lat;
    return v;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_i);
    while (busy_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o) check("idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic drive(input vec_t v);
    we_i = v.we; size_i = v.size; sign_i = v.sign; addr_i = v.addr; wdata_i = v.wdata;
    req_i = 1'b1;
  endtask

  task automatic push(input vec_t v, input int rc);
    exp_t e;
    int   nb;
    e.v = v; e.req_cyc = rc;
    sb.push_back(e);
    if (v.we && !v.err) begin
      nb = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
      for (int k = 0; k < nb; k++) exp_mem[v.addr[6:0] + 7'(k)] = v.wdata[8*k +: 8];
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 12) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() > 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    wait_idle();
    drive(v);
    push(v, cyc);
    @(posedge clk_i);
    #1 req_i = 1'b0;
    wait_drain();
  endtask

  vec_t tbl[27];
  int   diff;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2);
    tbl[1]  = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2);
    tbl[2]  = mk(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'h0, 2);
    tbl[3]  = mk(1, 2'b00, 0, 32'h12, 32'h000000AA, 0, 32'h0, 3);
    tbl[4]  = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11AA3344, 2);
    tbl[5]  = mk(1, 2'b10, 0, 32'h20, 32'h8001FF80, 0, 32'h0, 2);
    tbl[6]  = mk(0, 2'b00, 1, 32'h20, 32'h0, 0, 32'hFFFFFF80, 2);
    tbl[7]  = mk(0, 2'b00, 0, 32'h20, 32'h0, 0, 32'h00000080, 2);
    tbl[8]  = mk(0, 2'b01, 1, 32'h22, 32'h0, 0, 32'hFFFF8001, 2);
    tbl[9]  = mk(0, 2'b01, 0, 32'h22, 32'h0, 0, 32'h00008001, 2);
    tbl[10] = mk(0, 2'b00, 1, 32'h21, 32'h0, 0, 32'hFFFFFFFF, 2);
    tbl[11] = mk(0, 2'b00, 1, 32'h22, 32'h0, 0, 32'h00000001, 2);
    tbl[12] = mk(0, 2'b00, 1, 32'h23, 32'h0, 0, 32'hFFFFFF80, 2);
    tbl[13] = mk(1, 2'b01, 0, 32'h22, 32'h1234BEEF, 0, 32'h0, 3);
    tbl[14] = mk(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'hBEEFFF80, 2);
    tbl[15] = mk(0, 2'b01, 1, 32'h20, 32'h0, 0, 32'hFFFFFF80, 2);
    tbl[16] = mk(0, 2'b01, 0, 32'h21, 32'h0, 1, 32'h0, 1);
    tbl[17] = mk(0, 2'b10, 0, 32'h7E, 32'h0, 1, 32'h0, 1);
    tbl[18] = mk(0, 2'b10, 0, 32'h80, 32'h0, 1, 32'h0, 1);
    tbl[19] = mk(1, 2'b11, 0, 32'h0, 32'hFFFFFFFF, 1, 32'h0, 1);
    tbl[20] = mk(1, 2'b00, 0, 32'h80, 32'h00000055, 1, 32'h0, 1);
    tbl[21] = mk(1, 2'b10, 0, 32'hFFFFFFFC, 32'h12345678, 1, 32'h0, 1);
    tbl[22] = mk(1, 2'b10, 0, 32'h7C, 32'hCAFEF00D, 0, 32'h0, 2);
    tbl[23] = mk(1, 2'b00, 0, 32'h7F, 32'h00000011, 0, 32'h0, 3);
    tbl[24] = mk(0, 2'b00, 0, 32'h7F, 32'h0, 0, 32'h00000011, 2);
    tbl[25] = mk(1, 2'b00, 0, 32'h10, 32'hFFFFFF77, 0, 32'h0, 3);
    tbl[26] = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11AA3377, 2);

    // Reset state.
    #12;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_read", {31'd0, mem_read_o}, 32'd0);
    check("rst_write", {31'd0, mem_write_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    #11 rst_i = 1'b1;

    for (int i = 0; i < 27; i++) run_vec(tbl[i]);

    // Reset during RMW_RD of a byte store: write must be dropped.
    wait_idle();
    drive(mk(1, 2'b00, 0, 32'h12, 32'h00000055, 0, 32'h0, 3));
    @(posedge clk_i);
    #1 req_i = 1'b0;
    @(negedge clk_i);
    check("rmw_rd_read", {31'd0, mem_read_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_read", {31'd0, mem_read_o}, 32'd0);
    check("midrst_write", {31'd0, mem_write_o}, 32'd0);
    check("midrst_addr", mem_addr_o, 32'd0);
    check("midrst_rdata", rdata_o, 32'd0);
    @(negedge clk_i);
    #3 rst_i = 1'b1;
    run_vec(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11AA3377, 2));

    // Request pulses while busy must be ignored.
    wait_idle();
    drive(mk(1, 2'b00, 0, 32'h11, 32'h000000BB, 0, 32'h0, 3));
    push(mk(1, 2'b00, 0, 32'h11, 32'h000000BB, 0, 32'h0, 3), cyc);
    @(posedge clk_i);
    #1 drive(mk(1, 2'b10, 0, 32'h40, 32'hFFFFFFFF, 0, 32'h0, 2));
    @(posedge clk_i);
    @(posedge clk_i);
    #1 req_i = 1'b0;
    wait_drain();
    run_vec(mk(0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h0, 2));
    run_vec(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11AABB77, 2));

    // req_i held high: one load every 3 cycles, each starting from IDLE.
    wait_idle();
    drive(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11AABB77, 2));
    for (int k = 0; k < 3; k++) push(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11AABB77, 2), cyc + 3*k);
    repeat (9) @(negedge clk_i);
    req_i = 1'b0;
    check("held_req_pending", 32'(sb.size()), 32'd0);
    sb.delete();
    wait_idle();

    diff = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== exp_mem[i]) diff++;
    check("mem_image_diff_bytes", 32'(diff), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
